// File: rtl/pipo_pipe.sv
// pipo_pipe: DEPTH-stage elastic register chain with valid/ready handshake,
// global stall enable and synchronous flush. Define PIPO_PIPE_OCC_EN for the occ port.
module pipo_pipe #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enb,
    input  logic          sync_rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
`ifdef PIPO_PIPE_OCC_EN
    ,
    output logic [CW-1:0] occ
`endif
);

    logic [DW-1:0]    data_r [DEPTH];
    logic [DEPTH-1:0] vld_r;
    logic [DEPTH-1:0] rdy;

    // Tail-to-head ready chain, accumulated in a local to keep bits of rdy independent.
    always_comb begin
        logic acc;
        int unsigned idx;
        acc = out_ready;
        rdy = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx      = DEPTH - 1 - k;
            acc      = acc | !vld_r[idx];
            rdy[idx] = acc;
        end
    end

    assign in_ready  = enb & !sync_rst & rdy[0];
    assign out_valid = vld_r[DEPTH-1];
    assign out_data  = data_r[DEPTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_r <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) data_r[i] <= '0;
        end else if (sync_rst) begin
            vld_r <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) data_r[i] <= '0;
        end else if (enb) begin
            if (rdy[0]) begin
                vld_r[0] <= in_valid;
                if (in_valid) data_r[0] <= in_data;
            end
            // Bubbles propagate only the valid bit; data holds to avoid toggling.
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    vld_r[i] <= vld_r[i-1];
                    if (vld_r[i-1]) data_r[i] <= data_r[i-1];
                end
            end
        end
    end

`ifdef PIPO_PIPE_OCC_EN
    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = vld_r[DEPTH-1] & out_ready & enb & !sync_rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ <= '0;
        end else if (sync_rst) begin
            occ <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ <= occ + CW'(1);
        end else if (out_xfer && !in_xfer) begin
            occ <= occ - CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipo_pipe.sv
// Directed self-checking bench for pipo_pipe (DW=16, DEPTH=4); occ checks
// are active when PIPO_PIPE_OCC_EN is defined.
module tb_pipo_pipe;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          enb;
    logic          sync_rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
`ifdef PIPO_PIPE_OCC_EN
    logic [CW-1:0] occ;
`endif

    int nvec = 0;
    int nerr = 0;

    pipo_pipe #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .sync_rst (sync_rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
`ifdef PIPO_PIPE_OCC_EN
        ,
        .occ      (occ)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_occ(input string tag, input int unsigned exp);
`ifdef PIPO_PIPE_OCC_EN
        chk(tag, 32'(occ), 32'(exp));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; enb = 1'b0; sync_rst = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset / idle
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk_occ("rst_occ", 0);
        step();
        rst = 1'b0; enb = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Latency / throughput
        out_ready = 1'b1;
        for (int unsigned w = 1; w <= 16; w++) begin
            in_data = DW'(w); in_valid = 1'b1;
            #1;
            chk("thru_in_ready", 32'(in_ready), 32'd1);
            step();
            if (w == 3) chk("lat_not_yet", 32'(out_valid), 32'd0);
            if (w >= 4) begin
                chk("thru_valid", 32'(out_valid), 32'd1);
                chk("thru_data", 32'(out_data), 32'(w - 3));
            end
        end
        in_valid = 1'b0;
        for (int unsigned k = 1; k <= 3; k++) begin
            step();
            chk("tail_data", 32'(out_data), 32'(13 + k));
        end
        step();
        chk("thru_empty", 32'(out_valid), 32'd0);

        // Back-pressure
        out_ready = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            in_data = DW'(16'hA0A0 + k); in_valid = 1'b1;
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_data = 16'hA0A4;
        #1;
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_head", 32'(out_data), 32'hA0A0);
        chk_occ("bp_occ_full", 4);
        step();
        chk("bp_hold_head", 32'(out_data), 32'hA0A0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_same_cycle", 32'(in_ready), 32'd1);
        step();
        chk("bp_pop1", 32'(out_data), 32'hA0A1);
        chk_occ("bp_occ_pushpop", 4);
        in_valid = 1'b0;
        step(); chk("bp_pop2", 32'(out_data), 32'hA0A2);
        step(); chk("bp_pop3", 32'(out_data), 32'hA0A3);
        step(); chk("bp_pop4", 32'(out_data), 32'hA0A4);
        step(); chk("bp_empty", 32'(out_valid), 32'd0);
        chk_occ("bp_occ_empty", 0);

        // Stall with two words in flight
        in_valid = 1'b1; in_data = 16'h5001; step();
        in_data = 16'h5002; step();
        in_valid = 1'b0; step(); step();
        enb = 1'b0; in_valid = 1'b1; in_data = 16'h5003;
        #1;
        for (int unsigned k = 0; k < 3; k++) begin
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_data", 32'(out_data), 32'h5001);
            chk("stall_vld", 32'(dut.vld_r), 32'b1100);
            step();
        end
        chk_occ("stall_occ", 2);
        enb = 1'b1; in_valid = 1'b0;
        step(); chk("resume_data", 32'(out_data), 32'h5002);
        step(); chk("resume_empty", 32'(out_valid), 32'd0);

        // Flush of a full chain with enb=0
        out_ready = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            in_data = DW'(16'hC000 + k); in_valid = 1'b1;
            step();
        end
        chk("pre_flush_vld", 32'(dut.vld_r), 32'hF);
        sync_rst = 1'b1; enb = 1'b0; in_data = 16'hDEAD;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        sync_rst = 1'b0; enb = 1'b1; in_valid = 1'b0;
        chk("flush_vld", 32'(dut.vld_r), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_data", 32'(out_data), 32'd0);
        chk("flush_data0", 32'(dut.data_r[0]), 32'd0);
        chk_occ("flush_occ", 0);
        out_ready = 1'b1;
        step(); step(); step(); step();
        chk("flush_no_accept", 32'(out_valid), 32'd0);

        // Bubble collapse
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h1111; step();
        in_valid = 1'b0; step(); step();
        in_valid = 1'b1; in_data = 16'h2222; step();
        in_valid = 1'b0; step(); step();
        chk("bubble_vld", 32'(dut.vld_r), 32'b1100);
        chk("bubble_head", 32'(out_data), 32'h1111);
        chk("bubble_s2", 32'(dut.data_r[2]), 32'h2222);
        chk("bubble_in_ready", 32'(in_ready), 32'd1);
        chk_occ("bubble_occ", 2);
        out_ready = 1'b1;
        step(); chk("bubble_pop", 32'(out_data), 32'h2222);
        step(); chk("bubble_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h7777; step();
        in_valid = 1'b0; step(); step(); step();
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk_occ("mid_rst_occ", 0);
        step();
        rst = 1'b0;
        in_valid = 1'b1; in_data = 16'h8888;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("post_rst_accept", 32'(dut.vld_r), 32'b0001);
        chk("post_rst_data", 32'(dut.data_r[0]), 32'h8888);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
